icache_responder: RTL

- Responder side of the fetch-stage instruction-cache/TLB handshake.
- Accepts a fetch request as a 12-bit page index, followed one cycle later by the VPN.
- Translates with identity mapping and performs a direct-mapped lookup of 128-bit lines.
- On a miss, refills the line from a 32-bit memory port, then returns the whole line to fetch.
- Sits between the fetch stage and the memory/bus interface. It is used as the core's L1 I-cache front end and as the bench model for fetch.

---
 rtl/icache_pkg.sv | 24 ++
 rtl/icache_refill_ctrl.sv | 59 +++++
 rtl/icache_responder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types and constants for the fetch-side instruction cache responder.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_REQ,
    REFILL_DATA,
    RESPOND
  } state_e;

  localparam int LINE_W   = 128;
  localparam int BEAT_W   = 32;
  localparam int IDX_W    = 12;
  localparam int VPN_W    = 28;
  localparam int PA_W     = VPN_W + IDX_W;
  localparam int OFFSET_W = 4;

  // Tag bits left over once the line offset and set index are removed from the PA.
  function automatic int tagWidth(input int sets);
    return PA_W - OFFSET_W - $clog2(sets);
  endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// Refill engine: issues the line request, counts the four beats and gathers them
// into a fill buffer; the final beat is merged on the fly so the line is ready
// in the same cycle it arrives.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int REFILL_BEATS = 4
) (
  input  logic                       clk_i,
  input  logic                       rstN_i,
  input  logic                       reqActive_i,
  input  logic                       dataActive_i,
  input  logic [PA_W-OFFSET_W-1:0]   lineAddr_i,
  input  logic                       memReqReady_i,
  input  logic                       memRespValid_i,
  input  logic [BEAT_W-1:0]          memRespData_i,
  output logic                       memReqValid_o,
  output logic [PA_W-1:0]            memReqAddr_o,
  output logic                       lastBeat_o,
  output logic [LINE_W-1:0]          fullLine_o
);

  logic [1:0]               beatCnt_q, beatCnt_d;
  logic [LINE_W-BEAT_W-1:0] fillBuf_q, fillBuf_d;

  assign memReqValid_o = reqActive_i;
  assign memReqAddr_o  = {lineAddr_i, {OFFSET_W{1'b0}}};
  assign lastBeat_o    = dataActive_i & memRespValid_i & (beatCnt_q == 2'(REFILL_BEATS - 1));
  assign fullLine_o    = {memRespData_i, fillBuf_q};

  // Restart the beat count on request acceptance; store each early beat in its slot.
  always_comb begin
    beatCnt_d = beatCnt_q;
    fillBuf_d = fillBuf_q;
    if (reqActive_i && memReqReady_i) begin
      beatCnt_d = 2'd0;
    end else if (dataActive_i && memRespValid_i) begin
      beatCnt_d = beatCnt_q + 2'd1;
      case (beatCnt_q)
        2'd0:    fillBuf_d[BEAT_W-1:0]          = memRespData_i;
        2'd1:    fillBuf_d[2*BEAT_W-1:BEAT_W]   = memRespData_i;
        2'd2:    fillBuf_d[3*BEAT_W-1:2*BEAT_W] = memRespData_i;
        default: fillBuf_d = fillBuf_q;
      endcase
    end
  end

  // Beat counter and fill buffer registers.
  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      beatCnt_q <= 2'd0;
      fillBuf_q <= '0;
    end else begin
      beatCnt_q <= beatCnt_d;
      fillBuf_q <= fillBuf_d;
    end
  end

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache front end with identity translation: accepts a
// page index, then the VPN, looks up a 128-bit line and refills it on a miss.
module icache_responder
  import icache_pkg::*;
#(
  parameter int               SETS         = 64,
  parameter logic [VPN_W-1:0] VPN_LIMIT    = 28'h0000100,
  parameter int               REFILL_BEATS = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ICACHE_REQ_VALID,
  input  logic [IDX_W-1:0]   ICACHE_REQ_BITS_IDX,
  input  logic               ICACHE_REQ_BITS_KILL,
  input  logic               ICACHE_RESP_READY,
  input  logic               ICACHE_INVALIDATE,
  input  logic               TLB_REQ_VALID,
  input  logic [VPN_W-1:0]   TLB_REQ_BITS_VPN,
  output logic               ICACHE_RESP_VALID,
  output logic [LINE_W-1:0]  ICACHE_RESP_BITS_DATABLOCK,
  output logic               TLB_RESP_MISS,
  output logic               TLB_RESP_XCPT_IF,
  output logic               MEM_REQ_VALID,
  input  logic               MEM_REQ_READY,
  output logic [PA_W-1:0]    MEM_REQ_ADDR,
  input  logic               MEM_RESP_VALID,
  input  logic [BEAT_W-1:0]  MEM_RESP_DATA
);

  localparam int SB    = $clog2(SETS);
  localparam int TAG_W = tagWidth(SETS);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VPN_W-1:0]   vpn_q, vpn_d;
  logic               killed_q, killed_d;
  logic               xcpt_q, xcpt_d;
  logic [LINE_W-1:0]  respData_q, respData_d;
  logic [SETS-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]   tagArr_q [SETS];
  logic [LINE_W-1:0]  dataArr_q [SETS];
  logic [TAG_W-1:0]   rdTag_q;
  logic [LINE_W-1:0]  rdData_q;

  logic [PA_W-1:0]    lookupPa, storedPa;
  logic [SB-1:0]      reqSet, lineSet;
  logic               hit, lastBeat, unusedBits;
  logic [LINE_W-1:0]  fullLine;

  assign lookupPa   = {TLB_REQ_BITS_VPN, idx_q};
  assign storedPa   = {vpn_q, idx_q};
  assign reqSet     = ICACHE_REQ_BITS_IDX[OFFSET_W+SB-1:OFFSET_W];
  assign lineSet    = idx_q[OFFSET_W+SB-1:OFFSET_W];
  assign hit        = valid_q[lineSet] && (rdTag_q == lookupPa[PA_W-1:OFFSET_W+SB]);
  assign unusedBits = ^{lookupPa[OFFSET_W+SB-1:0], storedPa[OFFSET_W-1:0]};

  icache_refill_ctrl #(.REFILL_BEATS(REFILL_BEATS)) uRefill (
    .clk_i          (CLK),
    .rstN_i         (RST),
    .reqActive_i    (state_q == REFILL_REQ),
    .dataActive_i   (state_q == REFILL_DATA),
    .lineAddr_i     (storedPa[PA_W-1:OFFSET_W]),
    .memReqReady_i  (MEM_REQ_READY),
    .memRespValid_i (MEM_RESP_VALID),
    .memRespData_i  (MEM_RESP_DATA),
    .memReqValid_o  (MEM_REQ_VALID),
    .memReqAddr_o   (MEM_REQ_ADDR),
    .lastBeat_o     (lastBeat),
    .fullLine_o     (fullLine)
  );

  assign ICACHE_RESP_VALID          = (state_q == RESPOND) & ~ICACHE_REQ_BITS_KILL;
  assign ICACHE_RESP_BITS_DATABLOCK = respData_q;
  assign TLB_RESP_MISS              = 1'b0;
  assign TLB_RESP_XCPT_IF           = xcpt_q;

  // Next-state logic for the lookup/refill/response sequence and its side registers.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    vpn_d      = vpn_q;
    xcpt_d     = 1'b0;
    respData_d = respData_q;
    valid_d    = valid_q;
    killed_d   = ((state_q == REFILL_REQ) || (state_q == REFILL_DATA)) &&
                 (killed_q || ICACHE_REQ_BITS_KILL);
    case (state_q)
      IDLE: begin
        if (ICACHE_REQ_VALID && !ICACHE_REQ_BITS_KILL) begin
          idx_d   = ICACHE_REQ_BITS_IDX;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        vpn_d = TLB_REQ_BITS_VPN;
        if (ICACHE_REQ_BITS_KILL || !(ICACHE_RESP_READY && TLB_REQ_VALID)) begin
          state_d = IDLE;
        end else if (TLB_REQ_BITS_VPN >= VPN_LIMIT) begin
          xcpt_d  = 1'b1;
          state_d = IDLE;
        end else if (hit) begin
          respData_d = rdData_q;
          state_d    = RESPOND;
        end else begin
          state_d = REFILL_REQ;
        end
      end
      REFILL_REQ: begin
        if (MEM_REQ_READY) state_d = REFILL_DATA;
      end
      REFILL_DATA: begin
        if (lastBeat) begin
          respData_d       = fullLine;
          valid_d[lineSet] = 1'b1;
          state_d          = (killed_q || ICACHE_REQ_BITS_KILL) ? IDLE : RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (ICACHE_INVALIDATE) valid_d = '0;
  end

  // Control registers, cleared asynchronously so a reset abandons any refill.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      vpn_q      <= '0;
      killed_q   <= 1'b0;
      xcpt_q     <= 1'b0;
      respData_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      vpn_q      <= vpn_d;
      killed_q   <= killed_d;
      xcpt_q     <= xcpt_d;
      respData_q <= respData_d;
      valid_q    <= valid_d;
    end
  end

  // Tag/data arrays: registered read while idle, write when the last beat lands.
  always_ff @(posedge CLK) begin
    if (state_q == IDLE) begin
      rdTag_q  <= tagArr_q[reqSet];
      rdData_q <= dataArr_q[reqSet];
    end
    if (lastBeat) begin
      tagArr_q[lineSet]  <= storedPa[PA_W-1:OFFSET_W+SB];
      dataArr_q[lineSet] <= fullLine;
    end
  end

endmodule
